statebase_ctrl: RTL and testbench

Command-side driver for the three-state `en`-stepped sequencer (IDLE=00 -> S1=01 -> S2=10 -> IDLE).
- Accepts a target-state command over a valid/ready handshake.
- Issues single-cycle `en` pulses and watches the sequencer's `state_c`.
- Reports done, or an error code, once the target is reached or the attempt fails.
- Sits between software/control logic and the sequencer; it is the producer of `en`.

---
 rtl/statebase_pkg.sv | 37 +++
 rtl/statebase_tmo.sv | 31 +++
 rtl/statebase_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_statebase_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/statebase_pkg.sv
// Shared definitions for the statebase command-side controller:
// sequencer state codes, controller FSM states, error codes, step successor.
package statebase_pkg;

  // Codes reported by the driven sequencer on state_c
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_S1      = 2'b01;
  localparam logic [1:0] ST_S2      = 2'b10;
  localparam logic [1:0] ST_ILLEGAL = 2'b11;

  // Controller FSM states
  typedef enum logic [1:0] {
    C_IDLE  = 2'b00,
    C_PULSE = 2'b01,
    C_WAIT  = 2'b10,
    C_GAP   = 2'b11
  } ctrl_state_t;

  // err_code values
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_TGT = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL = 2'd3;

  // Successor of a sequencer state after one en pulse; illegal maps to illegal
  function automatic logic [1:0] next_state(input logic [1:0] code);
    logic [1:0] nxt;
    case (code)
      ST_IDLE: nxt = ST_S1;
      ST_S1:   nxt = ST_S2;
      ST_S2:   nxt = ST_IDLE;
      default: nxt = ST_ILLEGAL;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/statebase_tmo.sv
// Loadable up-counter with clear/increment and a reached-limit flag.
// Used both as the per-step timeout counter and as the inter-pulse gap counter.
module statebase_tmo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] lim,
  output logic         hit
);

  logic [W-1:0] cnt;

  // Counter register: clear wins over load, load over increment; holds at all-ones
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

  assign hit = (cnt == lim);

endmodule

// File: rtl/statebase_ctrl.sv
// Command-side driver for the three-state en-stepped sequencer.
// Accepts a target state, issues single-cycle en pulses, and reports done/err.
// Optional build macro STATEBASE_CTRL_STEP_CNT_EN adds a saturating step_cnt output.
//
// Handshake: a command is taken on any rising clk edge where cmd_vld && cmd_rdy;
// cmd_rdy is high exactly while the controller is in C_IDLE and does not depend
// on cmd_vld. The producer must hold cmd_tgt stable while cmd_vld is high.
module statebase_ctrl
  import statebase_pkg::*;
#(
  parameter int TO_W   = 8,
  parameter int TO_MAX = 16,
  parameter int GAP    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_vld,
  output logic       cmd_rdy,
  input  logic [1:0] cmd_tgt,
  input  logic [1:0] state_c,
  output logic       en,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
`ifdef STATEBASE_CTRL_STEP_CNT_EN
  ,
  output logic [15:0] step_cnt
`endif
);

  localparam int GAP_W = 4;

  ctrl_state_t state_q, state_d;
  logic [1:0]  tgt_q, tgt_d;
  logic [1:0]  exp_q, exp_d;
  logic        en_q, en_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic        to_load, to_inc, to_hit;
  logic        gap_load, gap_inc, gap_hit;
  logic        in_idle;

  assign in_idle = (state_q == C_IDLE);

  // The timeout counter is loaded with 1 so it equals the number of C_WAIT
  // cycles spent, including the current one; it fires on the TO_MAX-th cycle.
  statebase_tmo #(.W(TO_W)) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .clr      (in_idle),
    .load     (to_load),
    .inc      (to_inc),
    .load_val (TO_W'(1)),
    .lim      (TO_W'(TO_MAX)),
    .hit      (to_hit)
  );

  // Same counter type reused to count GAP idle cycles between en pulses
  statebase_tmo #(.W(GAP_W)) u_gap (
    .clk      (clk),
    .rst      (rst),
    .clr      (in_idle),
    .load     (gap_load),
    .inc      (gap_inc),
    .load_val (GAP_W'(1)),
    .lim      (GAP_W'(GAP)),
    .hit      (gap_hit)
  );

  // State and registered-output update
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= C_IDLE;
      tgt_q   <= 2'b00;
      exp_q   <= 2'b00;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      exp_q   <= exp_d;
      en_q    <= en_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    exp_d    = exp_q;
    en_d     = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;
    to_load  = 1'b0;
    to_inc   = 1'b0;
    gap_load = 1'b0;
    gap_inc  = 1'b0;
    case (state_q)
      C_IDLE: begin
        if (cmd_vld) begin
          tgt_d  = cmd_tgt;
          code_d = ERR_NONE;
          if (cmd_tgt == ST_ILLEGAL) begin
            err_d  = 1'b1;
            code_d = ERR_BAD_TGT;
          end else if (state_c == ST_ILLEGAL) begin
            err_d  = 1'b1;
            code_d = ERR_ILLEGAL;
          end else if (cmd_tgt == state_c) begin
            done_d = 1'b1;
          end else begin
            state_d = C_PULSE;
          end
        end
      end
      C_PULSE: begin
        en_d    = 1'b1;
        exp_d   = next_state(state_c);
        to_load = 1'b1;
        state_d = C_WAIT;
      end
      C_WAIT: begin
        to_inc = 1'b1;
        // An illegal expectation never counts as a match; it falls to the illegal check
        if ((state_c == exp_q) && (exp_q != ST_ILLEGAL)) begin
          if (exp_q == tgt_q) begin
            done_d  = 1'b1;
            state_d = C_IDLE;
          end else if (GAP == 0) begin
            state_d = C_PULSE;
          end else begin
            gap_load = 1'b1;
            state_d  = C_GAP;
          end
        end else if (state_c == ST_ILLEGAL) begin
          err_d   = 1'b1;
          code_d  = ERR_ILLEGAL;
          state_d = C_IDLE;
        end else if (to_hit) begin
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          state_d = C_IDLE;
        end
      end
      C_GAP: begin
        if (gap_hit) begin
          state_d = C_PULSE;
        end else begin
          gap_inc = 1'b1;
        end
      end
      default: state_d = C_IDLE;
    endcase
  end

  assign cmd_rdy  = in_idle;
  assign busy     = !in_idle;
  assign en       = en_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = code_q;

`ifdef STATEBASE_CTRL_STEP_CNT_EN
  // Count every en pulse as it is registered; saturate, cleared only by rst
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt <= 16'h0000;
    end else if (en_d && (step_cnt != 16'hFFFF)) begin
      step_cnt <= step_cnt + 16'h0001;
    end
  end
`else
  // No step counter in this build
`endif

endmodule

// File: tb/tb_statebase_ctrl.sv
// Testbench for statebase_ctrl: a behavioural sequencer model drives state_c,
// directed and random commands push expected responses into exp_q, and a
// negedge monitor pops and checks them when done/err appears.
module tb_statebase_ctrl;

  localparam int TO_MAX = 16;
  localparam int GAP    = 2;

  typedef struct packed {
    logic       is_err;
    logic [1:0] code;
    logic [7:0] lat;
    logic [1:0] pulses;
    logic [3:0] fen;
    logic [1:0] fin;
  } resp_t;
  localparam int RW = $bits(resp_t);

  // ---------------- clock / reset / signals ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_vld;
  logic       cmd_rdy;
  logic [1:0] cmd_tgt;
  logic [1:0] state_c;
  logic       en;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;
`ifdef STATEBASE_CTRL_STEP_CNT_EN
  logic [15:0] step_cnt;
`endif

  always #5 clk = ~clk;

  statebase_ctrl #(.TO_W(8), .TO_MAX(TO_MAX), .GAP(GAP)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_vld  (cmd_vld),
    .cmd_rdy  (cmd_rdy),
    .cmd_tgt  (cmd_tgt),
    .state_c  (state_c),
    .en       (en),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code)
`ifdef STATEBASE_CTRL_STEP_CNT_EN
    ,
    .step_cnt (step_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- sequencer model ----------------
  // mode 0: steps normally; 1: ignores en (stuck); 2: jumps to illegal on en
  int         mode_v = 0;
  logic       preset_req;
  logic [1:0] preset_val;
  logic [1:0] seq;

  always @(posedge clk) begin
    if (preset_req) seq <= preset_val;
    else if (en) begin
      if (mode_v == 1) seq <= seq;
      else if (mode_v == 2) seq <= 2'b11;
      else if (seq == 2'b11) seq <= 2'b11;
      else seq <= 2'((int'(seq) + 1) % 3);
    end
  end
  assign state_c = seq;

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];

  // Reference: outcome of one command from the start state, target and sequencer mode
  function automatic resp_t model(input int start, input int tgt, input int mode);
    resp_t r;
    int n;
    r = '0;
    r.lat = 8'd1;
    r.fin = 2'(start);
    if (tgt == 3) begin
      r.is_err = 1'b1; r.code = 2'd1;
    end else if (start == 3) begin
      r.is_err = 1'b1; r.code = 2'd3;
    end else if (tgt != start) begin
      n = (tgt - start + 3) % 3;
      r.fen = 4'd2;
      if (mode == 1) begin
        r.is_err = 1'b1; r.code = 2'd2; r.pulses = 2'd1; r.lat = 8'(2 + TO_MAX);
      end else if (mode == 2) begin
        r.is_err = 1'b1; r.code = 2'd3; r.pulses = 2'd1; r.lat = 8'd4; r.fin = 2'd3;
      end else begin
        r.pulses = 2'(n); r.lat = 8'(4 + (n - 1) * (GAP + 3)); r.fin = 2'(tgt);
      end
    end
    return r;
  endfunction

  // ---------------- monitor ----------------
  int   cyc = 0;
  int   acc_cyc = 0;
  int   pulses = 0;
  int   first_en = 0;
  int   tot_en = 0;
  logic en_prev = 1'b0;

  always @(negedge clk) begin
    resp_t e;
    cyc++;
    if (rst) begin
      en_prev = 1'b0;
      tot_en = 0;
    end else begin
      if (cmd_vld && cmd_rdy) begin
        acc_cyc = cyc; pulses = 0; first_en = 0;
      end
      if (en) begin
        chk("en_single_cycle", int'(en_prev), 0);
        pulses++;
        tot_en++;
        if (first_en == 0) first_en = cyc - acc_cyc;
      end
      en_prev = en;
      if (done || err) begin
        chk("done_err_exclusive", int'(done && err), 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_response", 1, 0);
        end else begin
          e = resp_t'(exp_q.pop_front());
          chk("resp_is_err", int'(err), int'(e.is_err));
          chk("resp_err_code", int'(err_code), int'(e.code));
          chk("resp_latency", cyc - acc_cyc, int'(e.lat));
          chk("resp_en_pulses", pulses, int'(e.pulses));
          chk("first_en_cycle", first_en, int'(e.fen));
          chk("final_state_c", int'(state_c), int'(e.fin));
          chk("rdy_at_resp", int'(cmd_rdy), 1);
          chk("busy_at_resp", int'(busy), 0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_empty(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      chk({name, "_response_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic send(input int start, input int tgt, input int mode);
    resp_t e;
    @(posedge clk); #1;
    preset_req = 1'b1; preset_val = 2'(start); mode_v = mode;
    @(posedge clk); #1;
    preset_req = 1'b0;
    e = model(start, tgt, mode);
    exp_q.push_back(RW'(e));
    cmd_vld = 1'b1; cmd_tgt = 2'(tgt);
    @(posedge clk); #1;
    cmd_vld = 1'b0;
    wait_empty("cmd");
    @(negedge clk);
    chk("err_code_held", int'(err_code), int'(e.code));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog_expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; cmd_vld = 1'b0; cmd_tgt = 2'b00;
    preset_req = 1'b1; preset_val = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd_rdy", int'(cmd_rdy), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_en", int'(en), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_err_code", int'(err_code), 0);
`ifdef STATEBASE_CTRL_STEP_CNT_EN
    chk("reset_step_cnt", int'(step_cnt), 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0; preset_req = 1'b0;

    // Directed cases
    send(0, 2, 0);   // two-step loop with gap
    send(1, 1, 0);   // already at target
    send(0, 3, 0);   // bad target
    send(0, 1, 1);   // timeout
    send(0, 1, 2);   // illegal observed state during wait
    send(3, 0, 0);   // illegal state at accept
    send(2, 1, 0);   // wrap-around two steps
    send(1, 2, 0);   // single step

    // Reset in the middle of a command (during the gap)
    @(posedge clk); #1;
    preset_req = 1'b1; preset_val = 2'b00; mode_v = 0;
    @(posedge clk); #1;
    preset_req = 1'b0; cmd_vld = 1'b1; cmd_tgt = 2'b10;
    @(posedge clk); #1;
    cmd_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("busy_in_gap", int'(busy), 1);
    @(negedge clk);
    chk("midrst_en", int'(en), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_cmd_rdy", int'(cmd_rdy), 1);
`ifdef STATEBASE_CTRL_STEP_CNT_EN
    chk("midrst_step_cnt", int'(step_cnt), 0);
`endif
    @(posedge clk); #1 rst = 1'b0;
    repeat (30) @(posedge clk);

    // Random commands
    for (int k = 0; k < 80; k++) begin
      int s, t, m, r;
      s = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      t = int'($urandom_range(0, 3));
      r = int'($urandom_range(0, 9));
      m = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
      send(s, t, m);
    end

`ifdef STATEBASE_CTRL_STEP_CNT_EN
    @(negedge clk);
    chk("step_cnt_total", int'(step_cnt), tot_en);
`endif
    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
